cpu_prog_loader: RTL

//  Program loader and run controller that sits in front of the cpu core.
//  - Accepts a byte stream over a valid/ready handshake and packs it into

---
 rtl/cpu_prog_loader_pkg.sv | 32 +++
 rtl/cpu_prog_loader_word_packer.sv | 61 ++++++
 rtl/cpu_prog_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_prog_loader_pkg.sv
// Shared definitions for the program loader.
//   - ld_state_e     : loader FSM encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   - BYTE_W         : stream byte width
//   - bytes_per_word : WORD_W/8, i.e. stream bytes packed into one RAM word
//   - idx_w          : index width for a table of a given depth (minimum 1)
//   - checksum_ok    : payload sum plus checksum byte must wrap to zero
package cpu_prog_loader_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2,
    LD_DONE = 2'd3
  } ld_state_e;

  localparam int BYTE_W = 8;

  function automatic int bytes_per_word(input int word_w);
    return word_w / BYTE_W;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] cks);
    logic [7:0] total;
    total = sum + cks;
    return (total == 8'd0);
  endfunction

endpackage

// File: rtl/cpu_prog_loader_word_packer.sv
// word_packer: assembles an MSB-first byte stream into WORD_W-bit words.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        drops any partial word (new load)
//   take_i         a byte is consumed on this edge
//   byte_i         the byte being consumed
//   word_valid_o   this byte completes a word (combinational, same edge)
//   word_o         completed word: earlier bytes in the upper bits
module word_packer
  import cpu_prog_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int BPW = bytes_per_word(WORD_W);

  if (BPW == 1) begin : g_single
    // One byte is already a full word; nothing to accumulate.
    assign word_o       = byte_i;
    assign word_valid_o = take_i & ~clear_i;
  end else begin : g_multi
    localparam int CW = idx_w(BPW);
    localparam logic [CW-1:0] LAST_C = CW'(BPW - 1);

    logic [WORD_W-9:0] shift_q;
    logic [CW-1:0]     cnt_q;

    // The incoming byte lands in the low bits, so a finished word is the
    // held bytes followed by this one.
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = take_i & ~clear_i & (cnt_q == LAST_C);

    // Byte counter and partial-word shifter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (clear_i) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (take_i) begin
        if (cnt_q == LAST_C) begin
          shift_q <= '0;
          cnt_q   <= '0;
        end else begin
          shift_q <= word_o[WORD_W-9:0];
          cnt_q   <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: loads a byte stream into program RAM, then runs the cpu.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   start, load_len      begin a load of load_len words (1..RAM_SIZE)
//   byte_in/_valid/_ready  byte stream handshake (taken when valid & ready)
//   cpu_halt             cpu halt level
//   ram_flat             program RAM, word i at [(i+1)*WORD_W-1 -: WORD_W]
//   cpu_rst              active-high cpu reset (low only in RUN)
//   clks                 clocks spent in RUN, saturating at CYCLE_LIMIT
//   busy, done, timeout, err  status; err is sticky until a valid start
// Build option: LOADER_CHECKSUM_EN adds one checksum byte after the payload;
// payload sum plus checksum must be 0 mod 256, otherwise the run is refused.
module cpu_prog_loader
  import cpu_prog_loader_pkg::*;
#(
  parameter int RAM_SIZE    = 16,
  parameter int WORD_W      = 32,
  parameter int CNT_W       = 16,
  parameter int CYCLE_LIMIT = 250
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(RAM_SIZE):0]  load_len,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  input  logic                       cpu_halt,
  output logic [RAM_SIZE*WORD_W-1:0] ram_flat,
  output logic                       cpu_rst,
  output logic [CNT_W-1:0]           clks,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic                       err
);

  localparam int LW = $clog2(RAM_SIZE) + 1;
  localparam int AW = idx_w(RAM_SIZE);
  localparam logic [LW-1:0]    ONE_L   = LW'(1);
  localparam logic [LW-1:0]    DEPTH_L = LW'(RAM_SIZE);
  localparam logic [CNT_W-1:0] LIMIT_L = CNT_W'(CYCLE_LIMIT);

  ld_state_e         state_q, state_d;
  logic [LW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [CNT_W-1:0]  clks_q, clks_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] ram_q [RAM_SIZE];

  logic              ram_we_s;
  logic              pk_clear_s;
  logic              take_s;
  logic              pk_take_s;
  logic              word_valid_s;
  logic [WORD_W-1:0] word_s;
  logic              len_ok_s;
  logic              last_word_s;
  logic [CNT_W-1:0]  clks_inc_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              cks_phase_q, cks_phase_d;
  // The checksum byte is not payload and must not reach the packer.
  assign pk_take_s = take_s & ~cks_phase_q;
`else
  assign pk_take_s = take_s;
`endif

  assign take_s      = byte_valid & byte_ready_q;
  assign len_ok_s    = (load_len != {LW{1'b0}}) && (load_len <= DEPTH_L);
  assign last_word_s = ((ptr_q + ONE_L) == len_q);
  assign clks_inc_s  = (clks_q == LIMIT_L) ? clks_q : (clks_q + CNT_W'(1));

  word_packer #(.WORD_W(WORD_W)) u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (pk_clear_s),
    .take_i       (pk_take_s),
    .byte_i       (byte_in),
    .word_valid_o (word_valid_s),
    .word_o       (word_s)
  );

  // Next-state and registered-output logic of the loader FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cpu_rst_d  = cpu_rst_q;
    clks_d     = clks_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    ram_we_s   = 1'b0;
    pk_clear_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    cks_phase_d = cks_phase_q;
`endif
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          if (len_ok_s) begin
            state_d    = LD_LOAD;
            ptr_d      = {LW{1'b0}};
            len_d      = load_len;
            clks_d     = {CNT_W{1'b0}};
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            err_d      = 1'b0;
            pk_clear_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_d       = 8'd0;
            cks_phase_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      LD_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (cks_phase_q) begin
          if (take_s) begin
            if (checksum_ok(sum_q, byte_in)) begin
              state_d   = LD_RUN;
              cpu_rst_d = 1'b0;
            end else begin
              state_d   = LD_DONE;
              err_d     = 1'b1;
              done_d    = 1'b1;
              cpu_rst_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          if (take_s) begin
            sum_d = sum_q + byte_in;
          end else begin
            sum_d = sum_q;
          end
          if (word_valid_s) begin
            ram_we_s = 1'b1;
            ptr_d    = ptr_q + ONE_L;
            if (last_word_s) begin
              cks_phase_d = 1'b1;
            end else begin
              cks_phase_d = 1'b0;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
`else
        if (word_valid_s) begin
          ram_we_s = 1'b1;
          ptr_d    = ptr_q + ONE_L;
          if (last_word_s) begin
            state_d   = LD_RUN;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = LD_LOAD;
          end
        end else begin
          ptr_d = ptr_q;
        end
`endif
      end
      LD_RUN: begin
        cpu_rst_d = 1'b0;
        clks_d    = clks_inc_s;
        // Halt is checked first so it wins over a simultaneous budget expiry.
        if (cpu_halt) begin
          state_d   = LD_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
          cpu_rst_d = 1'b1;
        end else if (clks_inc_s == LIMIT_L) begin
          state_d   = LD_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          cpu_rst_d = 1'b1;
        end else begin
          state_d = LD_RUN;
        end
      end
      default: begin
        state_d   = LD_IDLE;
        cpu_rst_d = 1'b1;
      end
    endcase
    byte_ready_d = (state_d == LD_LOAD);
    busy_d       = (state_d == LD_LOAD) || (state_d == LD_RUN);
  end

  // FSM state and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LD_IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      cpu_rst_q    <= 1'b1;
      clks_q       <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      cpu_rst_q    <= cpu_rst_d;
      clks_q       <= clks_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running payload checksum and checksum-byte phase flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q       <= 8'd0;
      cks_phase_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cks_phase_q <= cks_phase_d;
    end
  end
`endif

  // Program RAM: cleared by reset, written one completed word at a time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        ram_q[i] <= '0;
      end
    end else if (ram_we_s) begin
      ram_q[ptr_q[AW-1:0]] <= word_s;
    end
  end

  for (genvar g = 0; g < RAM_SIZE; g++) begin : g_flat
    assign ram_flat[g*WORD_W +: WORD_W] = ram_q[g];
  end

  assign byte_ready = byte_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign clks       = clks_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign err        = err_q;

endmodule
